// File: rtl/axi_pkg.sv
// Shared AXI definitions for the axi_master family.
// Holds the burst-type and response encodings and the read-channel FSM
// state enum, so that the read and (future) write halves agree on them.
package axi_pkg;

  localparam logic [1:0] BURST_INCR   = 2'b01;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_EXOKAY = 2'b01;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } rd_state_e;

endpackage

// File: rtl/axi_master_read_channel.sv
// AXI master read channel: turns one user burst-read request into one AXI
// AR transaction, streams the returned R beats to the user with zero
// latency, checks the response, and pulses done/err when the burst ends.
// Only one transaction is outstanding at a time.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      user request handshake (ready only in IDLE)
//   req_addr, req_len        burst start byte address, beats minus one
//   ARVALID..ARBURST         AXI read address channel (registered)
//   RVALID..RRESP            AXI read data channel (RREADY = rd_ready in DATA)
//   rd_valid..rd_last        user beat stream (pass-through of R channel)
//   done, err                one-cycle completion pulse and its error flag
module axi_master_read_channel
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned READ_CHANNEL_WIDTH = 32,
  parameter int unsigned READ_BURST_LEN     = 8
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [READ_BURST_LEN-1:0]     req_len,

  output logic                          ARVALID,
  input  logic                          ARREADY,
  output logic [ADDR_WIDTH-1:0]         ARADDR,
  output logic [READ_BURST_LEN-1:0]     ARLEN,
  output logic [2:0]                    ARSIZE,
  output logic [1:0]                    ARBURST,

  input  logic                          RVALID,
  output logic                          RREADY,
  input  logic [READ_CHANNEL_WIDTH-1:0] RDATA,
  input  logic                          RLAST,
  input  logic [1:0]                    RRESP,

  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [READ_CHANNEL_WIDTH-1:0] rd_data,
  output logic                          rd_last,

  output logic                          done,
  output logic                          err
);

  localparam int unsigned SIZE_LOG2 = $clog2(READ_CHANNEL_WIDTH / 8);

  // Clears the byte-offset bits so ARADDR is aligned to the beat size.
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    ~((ADDR_WIDTH'(1) << SIZE_LOG2) - ADDR_WIDTH'(1));

  rd_state_e                 state;
  logic [READ_BURST_LEN-1:0] beat_cnt;
  logic                      err_flag;

  logic in_data;
  logic last_beat;
  logic r_hs;
  logic beat_err;

  assign in_data   = (state == DATA);
  // ARLEN doubles as the latched burst length; it is held for the whole burst.
  assign last_beat = (beat_cnt == ARLEN);
  assign r_hs      = in_data && RVALID && rd_ready;
  // A beat is bad if its response is not OKAY or RLAST disagrees with the
  // beat count; the burst still runs to len+1 beats either way.
  assign beat_err  = (RRESP != RRESP_OKAY) || (RLAST != last_beat);

  assign req_ready = (state == IDLE);
  assign RREADY    = in_data && rd_ready;
  assign rd_valid  = in_data && RVALID;
  assign rd_data   = RDATA;
  assign rd_last   = in_data && last_beat;
  assign ARSIZE    = 3'(SIZE_LOG2);
  assign ARBURST   = BURST_INCR;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      err_flag <= 1'b0;
      ARVALID  <= 1'b0;
      ARADDR   <= '0;
      ARLEN    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (req_valid) begin
            ARADDR   <= req_addr & ADDR_MASK;
            ARLEN    <= req_len;
            beat_cnt <= '0;
            err_flag <= 1'b0;
            ARVALID  <= 1'b1;
            state    <= ADDR;
          end
        end

        ADDR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            state   <= DATA;
          end
        end

        DATA: begin
          if (r_hs) begin
            // Counter may wrap on the final beat of a maximal burst; the
            // compare happens before the increment, so that is harmless.
            beat_cnt <= beat_cnt + READ_BURST_LEN'(1);
            if (beat_err) begin
              err_flag <= 1'b1;
            end
            if (last_beat) begin
              done  <= 1'b1;
              err   <= err_flag || beat_err;
              state <= DONE;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master_read_channel.sv
// Self-checking bench for axi_master_read_channel. A directed stimulus
// process plays user requests and an AXI slave; expected AR fields, user
// beats and done/err results are queued at issue time and popped by an
// independent monitor whenever the DUT presents the matching output.
module tb_axi_master_read_channel;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          ARVALID;
  logic          ARREADY;
  logic [AW-1:0] ARADDR;
  logic [LW-1:0] ARLEN;
  logic [2:0]    ARSIZE;
  logic [1:0]    ARBURST;
  logic          RVALID;
  logic          RREADY;
  logic [DW-1:0] RDATA;
  logic          RLAST;
  logic [1:0]    RRESP;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          done;
  logic          err;

  axi_master_read_channel #(
    .ADDR_WIDTH        (AW),
    .READ_CHANNEL_WIDTH(DW),
    .READ_BURST_LEN    (LW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_len  (req_len),
    .ARVALID  (ARVALID),
    .ARREADY  (ARREADY),
    .ARADDR   (ARADDR),
    .ARLEN    (ARLEN),
    .ARSIZE   (ARSIZE),
    .ARBURST  (ARBURST),
    .RVALID   (RVALID),
    .RREADY   (RREADY),
    .RDATA    (RDATA),
    .RLAST    (RLAST),
    .RRESP    (RRESP),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } ar_exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_exp_t;

  ar_exp_t   ar_q[$];
  beat_exp_t beat_q[$];
  logic      done_q[$];

  int n_checks  = 0;
  int n_fail    = 0;
  int done_seen = 0;
  bit in_data   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int id, input int b);
    return DW'(32'hA500_0000 | (id << 16) | b);
  endfunction

  // Monitor / scoreboard
  initial begin
    ar_exp_t   ae;
    beat_exp_t be;
    logic      de;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ARVALID && ARREADY) begin
          if (ar_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL ar_unexpected: got ARADDR 0x%0h expected no AR handshake", ARADDR);
          end else begin
            ae = ar_q.pop_front();
            check("araddr",  64'(ARADDR),  64'(ae.addr));
            check("arlen",   64'(ARLEN),   64'(ae.len));
            check("arsize",  64'(ARSIZE),  64'(2));
            check("arburst", 64'(ARBURST), 64'(1));
          end
        end
        if (rd_valid && rd_ready) begin
          if (beat_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_unexpected: got rd_data 0x%0h expected no beat", rd_data);
          end else begin
            be = beat_q.pop_front();
            check("rd_data", 64'(rd_data), 64'(be.data));
            check("rd_last", 64'(rd_last), 64'(be.last));
          end
        end
        if (in_data) begin
          check("rready_mirror",  64'(RREADY),  64'(rd_ready));
          check("rd_valid_pass",  64'(rd_valid), 64'(RVALID));
          check("arvalid_in_data", 64'(ARVALID), 64'(0));
        end
        if (done) begin
          done_seen++;
          if (done_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_unexpected: got done=1 expected no done pulse");
          end else begin
            de = done_q.pop_front();
            check("done_err", 64'(err), 64'(de));
          end
        end
      end
    end
  end

  // One burst: user request plus slave behaviour, with expectations queued.
  task automatic run_burst(input int id, input logic [AW-1:0] addr, input int len,
                           input logic [AW-1:0] exp_addr, input int ar_delay,
                           input int bad_beat, input int rlast_at, input bit toggle,
                           input int abort_at, input logic exp_err);
    int cyc;
    int b;
    int start_done;
    bit hs;

    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("req_ready_idle", 64'(req_ready), 64'(1));

    ar_q.push_back('{addr: exp_addr, len: LW'(len)});
    for (int i = 0; i <= len; i++) beat_q.push_back('{data: pat(id, i), last: (i == len)});
    if (abort_at < 0) done_q.push_back(exp_err);

    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = LW'(len);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("req_ready_busy", 64'(req_ready), 64'(0));

    for (int i = 0; i < ar_delay; i++) begin
      check("arvalid_hold", 64'(ARVALID), 64'(1));
      @(posedge clk); #1;
    end
    ARREADY = 1'b1;
    cyc = 0;
    while (!ARVALID && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 20) check("ar_timeout", 64'(ARVALID), 64'(1));
    @(posedge clk); #1;
    ARREADY = 1'b0;
    in_data = 1'b1;

    b   = 0;
    cyc = 0;
    while (b <= len && cyc < 2000) begin
      if (b == abort_at) begin
        rst = 1'b1;
        in_data = 1'b0;
        #1;
        check("abort_arvalid", 64'(ARVALID),  64'(0));
        check("abort_done",    64'(done),     64'(0));
        check("abort_err",     64'(err),      64'(0));
        check("abort_rready",  64'(RREADY),   64'(0));
        check("abort_rdvalid", 64'(rd_valid), 64'(0));
        check("abort_araddr",  64'(ARADDR),   64'(0));
        check("abort_arlen",   64'(ARLEN),    64'(0));
        RVALID = 1'b0;
        RLAST  = 1'b0;
        RRESP  = 2'b00;
        beat_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_req_ready", 64'(req_ready), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done), 64'(0));
        return;
      end
      RVALID = 1'b1;
      RDATA  = pat(id, b);
      RLAST  = (rlast_at < 0) ? (b == len) : (b == rlast_at);
      RRESP  = (b == bad_beat) ? 2'b10 : 2'b00;
      #1;
      hs = RREADY;
      @(posedge clk); #1;
      if (hs) b++;
      if (toggle) rd_ready = ~rd_ready;
      cyc++;
    end
    RVALID   = 1'b0;
    RLAST    = 1'b0;
    RRESP    = 2'b00;
    in_data  = 1'b0;
    rd_ready = 1'b1;
    if (b <= len) check("beat_timeout", 64'(b), 64'(len + 1));

    start_done = done_seen;
    cyc = 0;
    while (done_seen == start_done && cyc < 10) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("done_seen", 64'(done_seen - start_done), 64'(1));
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'(0));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    ARREADY   = 1'b0;
    RVALID    = 1'b0;
    RDATA     = '0;
    RLAST     = 1'b0;
    RRESP     = 2'b00;
    rd_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arvalid",  64'(ARVALID),  64'(0));
    check("rst_done",     64'(done),     64'(0));
    check("rst_err",      64'(err),      64'(0));
    check("rst_araddr",   64'(ARADDR),   64'(0));
    check("rst_arlen",    64'(ARLEN),    64'(0));
    check("rst_rready",   64'(RREADY),   64'(0));
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    rst = 1'b0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'(1));
    @(posedge clk); #1;

    //        id addr          len exp_addr     ard bad rlast tog abort err
    run_burst(1, 32'h0000_1000,   7, 32'h0000_1000, 3, -1, -1, 0, -1, 1'b0);
    run_burst(2, 32'h0000_2000,   0, 32'h0000_2000, 1,  0, -1, 0, -1, 1'b1);
    run_burst(3, 32'h0000_3000,   3, 32'h0000_3000, 0, -1, -1, 1, -1, 1'b0);
    run_burst(4, 32'h0000_4000,   3, 32'h0000_4000, 2, -1,  1, 0, -1, 1'b1);
    run_burst(5, 32'h0000_5000,   7, 32'h0000_5000, 1, -1, -1, 0,  3, 1'b0);
    run_burst(6, 32'h0000_6000,   1, 32'h0000_6000, 0, -1, -1, 0, -1, 1'b0);
    run_burst(7, 32'h0000_1003, 255, 32'h0000_1000, 0, -1, -1, 0, -1, 1'b0);
    run_burst(8, 32'h0000_700A,   2, 32'h0000_7008, 1, -1,  9, 0, -1, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("ar_q_empty",   64'(ar_q.size()),   64'(0));
    check("beat_q_empty", 64'(beat_q.size()), 64'(0));
    check("done_q_empty", 64'(done_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
